// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Carries one request channel and one response channel.
interface if_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem fetch, redirect/drop handling,
// misaligned-target and access-fault exceptions presented to decode.
module if_stage #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.master   imem,
    input  logic         i_redirect_valid,
    input  logic [63:0]  i_redirect_pc,
    input  logic         i_id_ready,
    output logic         o_inst_valid,
    output logic [31:0]  o_inst,
    output logic [63:0]  o_inst_addr,
    output logic [1:0]   o_if_excp
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, TRAP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_pc;
    logic [63:0] w_pc_next;
    logic [63:0] r_req_addr;
    logic [63:0] w_req_addr_next;
    logic        r_drop;
    logic        w_drop_next;
    logic [31:0] r_inst;
    logic [31:0] w_inst_next;
    logic [63:0] r_inst_addr;
    logic [63:0] w_inst_addr_next;
    logic [1:0]  r_excp;
    logic [1:0]  w_excp_next;
    logic        w_load;
    logic [63:0] w_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= REQ;
            r_pc        <= PC_RESET;
            r_req_addr  <= PC_RESET;
            r_drop      <= 1'b0;
            r_inst      <= 32'h0;
            r_inst_addr <= 64'h0;
            r_excp      <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_req_addr  <= w_req_addr_next;
            r_drop      <= w_drop_next;
            r_inst      <= w_inst_next;
            r_inst_addr <= w_inst_addr_next;
            r_excp      <= w_excp_next;
        end
    end

    // r_req_addr is kept apart from r_pc so a pending request stays stable across redirects.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_req_addr_next  = r_req_addr;
        w_drop_next      = r_drop;
        w_inst_next      = r_inst;
        w_inst_addr_next = r_inst_addr;
        w_excp_next      = r_excp;
        w_load           = 1'b0;
        w_target         = r_pc;

        case (r_state)
            REQ: begin
                if (i_redirect_valid) begin
                    w_pc_next   = i_redirect_pc;
                    w_drop_next = 1'b1;
                end
                if (imem.req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (i_redirect_valid) begin
                    if (imem.resp_valid) begin
                        w_load   = 1'b1;
                        w_target = i_redirect_pc;
                    end else begin
                        w_pc_next   = i_redirect_pc;
                        w_drop_next = 1'b1;
                    end
                end else if (imem.resp_valid) begin
                    if (r_drop) begin
                        w_load   = 1'b1;
                        w_target = r_pc;
                    end else begin
                        w_inst_next      = imem.resp_err ? NOP_INST : imem.resp_data;
                        w_inst_addr_next = r_pc;
                        w_excp_next      = {imem.resp_err, 1'b0};
                        w_state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (i_redirect_valid) begin
                    w_load   = 1'b1;
                    w_target = i_redirect_pc;
                end else if (i_id_ready) begin
                    if (r_excp != 2'b00) begin
                        w_state_next = TRAP;
                    end else begin
                        w_load   = 1'b1;
                        w_target = r_pc + 64'd4;
                    end
                end
            end
            TRAP: begin
                if (i_redirect_valid) begin
                    w_load   = 1'b1;
                    w_target = i_redirect_pc;
                end
            end
            default: begin
                w_state_next = REQ;
            end
        endcase

        // A misaligned target is never fetched; it is presented directly as an exception.
        if (w_load) begin
            w_pc_next   = w_target;
            w_drop_next = 1'b0;
            if (w_target[1:0] != 2'b00) begin
                w_state_next     = HOLD;
                w_inst_next      = NOP_INST;
                w_inst_addr_next = w_target;
                w_excp_next      = 2'b01;
            end else begin
                w_state_next    = REQ;
                w_req_addr_next = w_target;
            end
        end
    end

    assign imem.req_valid = (r_state == REQ) && !rst;
    assign imem.req_addr  = r_req_addr;
    assign o_inst_valid   = (r_state == HOLD) && !rst;
    assign o_inst         = r_inst;
    assign o_inst_addr    = r_inst_addr;
    assign o_if_excp      = r_excp;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by a randomized run scored
// against an architectural next-PC model with an address-derived instruction memory.
module tb_if_stage;

    localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirectValid;
    logic [63:0] redirectPc;
    logic        idReady;
    logic        instValid;
    logic [31:0] inst;
    logic [63:0] instAddr;
    logic [1:0]  ifExcp;

    int checks = 0;
    int errors = 0;

    if_stage_if imemBus();

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imemBus),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .i_id_ready       (idReady),
        .o_inst_valid     (instValid),
        .o_inst           (inst),
        .o_inst_addr      (instAddr),
        .o_if_excp        (ifExcp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then returns at the falling edge.
    task automatic applyStimulus(input logic r, input logic rdV, input logic [63:0] rdPc,
                                 input logic idR, input logic rqR, input logic rsV,
                                 input logic [31:0] rsD, input logic rsE);
        @(posedge clk);
        #1;
        rst                = r;
        redirectValid      = rdV;
        redirectPc         = rdPc;
        idReady            = idR;
        imemBus.req_ready  = rqR;
        imemBus.resp_valid = rsV;
        imemBus.resp_data  = rsD;
        imemBus.resp_err   = rsE;
        @(negedge clk);
    endtask

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_0003;
    endfunction

    function automatic logic memErr(input logic [63:0] a);
        return a[6:2] == 5'd13;
    endfunction

    function automatic logic [63:0] randomTarget();
        logic [63:0] t;
        if ($urandom % 8 == 0)
            t = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 7)) * 64'd4;
        else
            t = PCR + 64'($urandom_range(0, 255)) * 64'd4;
        if ($urandom % 4 == 0)
            t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        logic [63:0] expPc;
        logic [31:0] expInst;
        logic [1:0]  expExcp;
        logic [63:0] respAddr;
        logic [63:0] prevAddr;
        logic [63:0] rdPc;
        logic [31:0] rsD;
        logic        rdV;
        logic        rsV;
        logic        rsE;
        bit          outstanding;
        bit          trapped;
        bit          prevHold;
        int          delay;
        int          idle;
        int          presented;

        rst                = 1'b1;
        redirectValid      = 1'b0;
        redirectPc         = 64'h0;
        idReady            = 1'b0;
        imemBus.req_ready  = 1'b0;
        imemBus.resp_valid = 1'b0;
        imemBus.resp_data  = 32'h0;
        imemBus.resp_err   = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_req_valid", imemBus.req_valid, 0);
        checkOutput("rst_inst_valid", instValid, 0);
        checkOutput("rst_inst", inst, 0);
        checkOutput("rst_inst_addr", instAddr, 0);
        checkOutput("rst_excp", ifExcp, 0);

        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("first_req_valid", imemBus.req_valid, 1);
        checkOutput("first_req_addr", imemBus.req_addr, PCR);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0010_0093, 0);
        checkOutput("wait_req_valid", imemBus.req_valid, 0);
        checkOutput("wait_inst_valid", instValid, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("first_inst_valid", instValid, 1);
        checkOutput("first_inst", inst, 32'h0010_0093);
        checkOutput("first_inst_addr", instAddr, PCR);
        checkOutput("first_excp", ifExcp, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("seq_req_valid", imemBus.req_valid, 1);
        checkOutput("seq_req_addr", imemBus.req_addr, PCR + 64'd4);

        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0020_8113, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("stall_inst_valid", instValid, 1);
            checkOutput("stall_inst", inst, 32'h0020_8113);
            checkOutput("stall_inst_addr", instAddr, PCR + 64'd4);
            checkOutput("stall_no_req", imemBus.req_valid, 0);
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("stall_next_addr", imemBus.req_addr, PCR + 64'd8);
        checkOutput("stall_next_valid", imemBus.req_valid, 1);

        applyStimulus(0, 1, PCR + 64'h100, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drop_no_req", imemBus.req_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1111_1111, 0);
        checkOutput("drop_no_inst", instValid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drop_no_inst2", instValid, 0);
        checkOutput("drop_req_valid", imemBus.req_valid, 1);
        checkOutput("drop_req_addr", imemBus.req_addr, PCR + 64'h100);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0050_0293, 0);

        applyStimulus(0, 1, PCR + 64'h180, 1, 0, 0, 0, 0);
        checkOutput("hold_redir_inst", inst, 32'h0050_0293);
        checkOutput("hold_redir_addr", instAddr, PCR + 64'h100);
        applyStimulus(0, 1, PCR + 64'h102, 0, 0, 0, 0, 0);
        checkOutput("redir_win_valid", instValid, 0);
        checkOutput("redir_win_addr", imemBus.req_addr, PCR + 64'h180);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("req_stable_valid", imemBus.req_valid, 1);
        checkOutput("req_stable_addr", imemBus.req_addr, PCR + 64'h180);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
        checkOutput("mis_drain_inst_valid", instValid, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("mis_inst_valid", instValid, 1);
        checkOutput("mis_inst", inst, NOP);
        checkOutput("mis_inst_addr", instAddr, PCR + 64'h102);
        checkOutput("mis_excp", ifExcp, 2'b01);
        checkOutput("mis_no_req", imemBus.req_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h5555_5555, 0);
        checkOutput("trap_no_req", imemBus.req_valid, 0);
        checkOutput("trap_no_inst", instValid, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("trap_no_req2", imemBus.req_valid, 0);
        applyStimulus(0, 1, PCR + 64'h200, 0, 1, 0, 0, 0);
        checkOutput("trap_redir_cycle", imemBus.req_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("trap_exit_valid", imemBus.req_valid, 1);
        checkOutput("trap_exit_addr", imemBus.req_addr, PCR + 64'h200);

        applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("fault_inst", inst, NOP);
        checkOutput("fault_excp", ifExcp, 2'b10);
        checkOutput("fault_inst_addr", instAddr, PCR + 64'h200);
        applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0);
        checkOutput("fault_trap_inst", instValid, 0);
        checkOutput("fault_trap_req", imemBus.req_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("top_req_addr", imemBus.req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0033, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("top_inst_addr", instAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("top_inst", inst, 32'h0000_0033);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("wrap_req_valid", imemBus.req_valid, 1);
        checkOutput("wrap_req_addr", imemBus.req_addr, 64'h0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst_req_valid", imemBus.req_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h7777_7777, 0);
        checkOutput("midrst_req_valid2", imemBus.req_valid, 1);
        checkOutput("midrst_req_addr", imemBus.req_addr, PCR);
        checkOutput("midrst_no_inst", instValid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst_late_resp", instValid, 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        expPc       = PCR;
        trapped     = 0;
        outstanding = 0;
        prevHold    = 0;
        prevAddr    = 64'h0;
        respAddr    = 64'h0;
        delay       = 0;
        idle        = 0;
        presented   = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rsV = 1'b0;
            rsD = $urandom;
            rsE = ($urandom % 2) == 1;
            if (outstanding) begin
                if (delay == 0) begin
                    rsV         = 1'b1;
                    rsD         = memWord(respAddr);
                    rsE         = memErr(respAddr);
                    outstanding = 0;
                end else begin
                    delay--;
                end
            end else begin
                rsV = ($urandom % 8) == 0;
            end
            rdV  = ($urandom % 12) == 0;
            rdPc = randomTarget();
            applyStimulus(0, rdV, rdPc, ($urandom % 2) == 1, ($urandom % 5) < 3, rsV, rsD, rsE);

            if (expPc[1:0] != 2'b00) begin
                expInst = NOP;
                expExcp = 2'b01;
            end else if (memErr(expPc)) begin
                expInst = NOP;
                expExcp = 2'b10;
            end else begin
                expInst = memWord(expPc);
                expExcp = 2'b00;
            end

            if (prevHold) begin
                checkOutput("rnd_req_hold_valid", imemBus.req_valid, 1);
                checkOutput("rnd_req_hold_addr", imemBus.req_addr, prevAddr);
            end
            if (imemBus.req_valid)
                checkOutput("rnd_req_align", 64'(imemBus.req_addr[1:0]), 0);
            if (trapped)
                checkOutput("rnd_trap_quiet", {62'h0, imemBus.req_valid, instValid}, 0);
            if (instValid) begin
                checkOutput("rnd_inst_addr", instAddr, expPc);
                checkOutput("rnd_inst", inst, expInst);
                checkOutput("rnd_excp", ifExcp, expExcp);
                presented++;
            end

            if (imemBus.req_valid && imemBus.req_ready) begin
                checkOutput("rnd_one_outstanding", 64'(outstanding), 0);
                outstanding = 1;
                respAddr    = imemBus.req_addr;
                delay       = $urandom_range(0, 3);
            end
            prevHold = imemBus.req_valid && !imemBus.req_ready;
            prevAddr = imemBus.req_addr;

            if (redirectValid) begin
                expPc   = redirectPc;
                trapped = 0;
            end else if (instValid && idReady) begin
                if (expExcp != 2'b00)
                    trapped = 1;
                else
                    expPc = expPc + 64'd4;
            end

            if (instValid || trapped)
                idle = 0;
            else
                idle++;
            if (idle >= 200) begin
                checkOutput("rnd_watchdog_idle", 64'(idle), 0);
                idle = 0;
            end
        end
        checkOutput("rnd_progress", 64'(presented >= 100), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
